// File: rtl/div_defs_pkg.sv
// Shared definitions for the iterative divider: FSM states, width default and fill constants.
package div_defs;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  localparam int ANCHO_DEF = 32;

  localparam logic [ANCHO_DEF-1:0] TODOS_UNOS   = '1;
  localparam logic [ANCHO_DEF-1:0] MAS_NEGATIVO = {1'b1, {(ANCHO_DEF-1){1'b0}}};

endpackage

// File: rtl/div_paso.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract the divisor.
module div_paso #(
  parameter int ANCHO = 32
) (
  input  logic [ANCHO-1:0] rem,
  input  logic [ANCHO-1:0] quot,
  input  logic [ANCHO-1:0] divisor,
  output logic [ANCHO-1:0] rem_sig,
  output logic [ANCHO-1:0] quot_sig
);

  logic [ANCHO:0] desplazado;
  logic [ANCHO:0] prueba;

  always_comb begin
    desplazado = {rem, quot[ANCHO-1]};
    prueba     = desplazado - {1'b0, divisor};
    // rem < divisor always holds, so bit ANCHO of the trial is a true sign bit
    if (prueba[ANCHO]) begin
      rem_sig  = desplazado[ANCHO-1:0];
      quot_sig = {quot[ANCHO-2:0], 1'b0};
    end else begin
      rem_sig  = prueba[ANCHO-1:0];
      quot_sig = {quot[ANCHO-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_iterativo.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per clock.
// Optional early termination on leading zeros of the dividend: DIV_TERMINO_TEMPRANO_EN.
module div_iterativo
  import div_defs::*;
#(
  parameter int ANCHO    = ANCHO_DEF,
  parameter int CUENTA_W = 6
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             inicio,
  input  logic             con_signo,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] resto
);

  localparam logic [ANCHO-1:0] UNOS_A    = TODOS_UNOS[ANCHO-1:0];
  localparam logic [ANCHO-1:0] MAS_NEG_A = MAS_NEGATIVO[ANCHO_DEF-1 -: ANCHO];

  estado_t             estado;
  logic [CUENTA_W-1:0] cuenta;
  logic [ANCHO-1:0]    rem;
  logic [ANCHO-1:0]    quot;
  logic [ANCHO-1:0]    divisor;
  logic                neg_q;
  logic                neg_r;

  logic [ANCHO-1:0]    abs_a;
  logic [ANCHO-1:0]    abs_b;
  logic                div_cero;
  logic                desborde;
  logic [ANCHO-1:0]    rem_sig;
  logic [ANCHO-1:0]    quot_sig;

  always_comb begin
    abs_a    = (con_signo && a[ANCHO-1]) ? -a : a;
    abs_b    = (con_signo && b[ANCHO-1]) ? -b : b;
    div_cero = (b == '0);
    desborde = con_signo && (a == MAS_NEG_A) && (b == UNOS_A);
  end

`ifdef DIV_TERMINO_TEMPRANO_EN
  logic [CUENTA_W-1:0] ceros;

  // Highest set bit wins; all-zero dividend is routed to the fast path
  always_comb begin
    ceros = '0;
    for (int unsigned i = 0; i < ANCHO; i++) begin
      if (abs_a[i]) ceros = CUENTA_W'(ANCHO - 1 - i);
    end
  end
`endif

  div_paso #(.ANCHO(ANCHO)) u_paso (
    .rem      (rem),
    .quot     (quot),
    .divisor  (divisor),
    .rem_sig  (rem_sig),
    .quot_sig (quot_sig)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado   <= REPOSO;
      cuenta   <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      cociente <= '0;
      resto    <= '0;
    end else begin
      listo <= 1'b0;
      case (estado)
        REPOSO: begin
          if (inicio) begin
            ocupado <= 1'b1;
            divisor <= abs_b;
            neg_q   <= con_signo & (a[ANCHO-1] ^ b[ANCHO-1]);
            neg_r   <= con_signo & a[ANCHO-1];
            rem     <= '0;
            if (div_cero) begin
              quot   <= UNOS_A;
              rem    <= a;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
              estado <= FIN;
            end else if (desborde) begin
              quot   <= a;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
              estado <= FIN;
`ifdef DIV_TERMINO_TEMPRANO_EN
            end else if (abs_a == '0) begin
              quot   <= '0;
              estado <= FIN;
            end else begin
              quot   <= abs_a << ceros;
              cuenta <= CUENTA_W'(ANCHO) - ceros;
              estado <= CALCULO;
            end
`else
            end else begin
              quot   <= abs_a;
              cuenta <= CUENTA_W'(ANCHO);
              estado <= CALCULO;
            end
`endif
          end
        end
        CALCULO: begin
          rem    <= rem_sig;
          quot   <= quot_sig;
          cuenta <= cuenta - 1'b1;
          if (cuenta == CUENTA_W'(1)) estado <= FIN;
        end
        FIN: begin
          cociente <= neg_q ? -quot : quot;
          resto    <= neg_r ? -rem : rem;
          listo    <= 1'b1;
          ocupado  <= 1'b0;
          estado   <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iterativo.sv
// Directed bench for div_iterativo: expected results queued at launch, checked when listo pulses.
module tb_div_iterativo;

  logic        clk = 1'b0;
  logic        nreset;
  logic        inicio;
  logic        con_signo;
  logic [31:0] a;
  logic [31:0] b;
  logic        ocupado;
  logic        listo;
  logic [31:0] cociente;
  logic [31:0] resto;

  div_iterativo #(.ANCHO(32), .CUENTA_W(6)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .inicio    (inicio),
    .con_signo (con_signo),
    .a         (a),
    .b         (b),
    .ocupado   (ocupado),
    .listo     (listo),
    .cociente  (cociente),
    .resto     (resto)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          ciclo;
  } esp_t;

  esp_t sb[$];
  int   ciclo   = 0;
  int   total   = 0;
  int   fallos  = 0;
  int   listos  = 0;

  always @(posedge clk) ciclo <= ciclo + 1;

  task automatic chequea(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fallos++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Cycles from the accepting edge to the edge that raises listo
  function automatic int lat_esp(input logic [31:0] da, input logic [31:0] db, input logic s);
    logic [31:0] mag;
    int          z;
    if (db == 32'h0) return 1;
    if (s && da == 32'h8000_0000 && db == 32'hFFFF_FFFF) return 1;
    mag = (s && da[31]) ? (32'h0 - da) : da;
`ifdef DIV_TERMINO_TEMPRANO_EN
    if (mag == 32'h0) return 1;
    z = 0;
    while (!mag[31]) begin
      mag = mag << 1;
      z++;
    end
    return (32 - z) + 1;
`else
    z = 0;
    return 33 + z + int'(mag[0] & 1'b0);
`endif
  endfunction

  always @(negedge clk) begin
    if (listo === 1'b1) begin
      listos++;
      if (sb.size() == 0) begin
        chequea("listo_sin_op", {31'h0, listo}, 32'h0);
      end else begin
        esp_t e;
        e = sb.pop_front();
        chequea("cociente", cociente, e.q);
        chequea("resto", resto, e.r);
        chequea("latencia", ciclo, e.ciclo);
      end
    end
  end

  task automatic lanzar(input logic [31:0] da, input logic [31:0] db, input logic s,
                        input logic [31:0] q, input logic [31:0] r);
    a = da;
    b = db;
    con_signo = s;
    inicio = 1'b1;
    sb.push_back('{q, r, ciclo + 1 + lat_esp(da, db, s)});
    @(negedge clk);
    inicio = 1'b0;
    a = $urandom;
    b = $urandom;
    con_signo = 1'(($urandom) & 1);
  endtask

  task automatic espera(input string tag, output int occ);
    bit ok;
    ok  = 1'b0;
    occ = 0;
    for (int i = 0; i < 200; i++) begin
      if (listo === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (ocupado === 1'b1) occ++;
      @(negedge clk);
    end
    chequea({tag, "_termina"}, {31'h0, ok}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int occ;
    int t1;
    nreset    = 1'b0;
    inicio    = 1'b0;
    con_signo = 1'b0;
    a         = '0;
    b         = '0;
    @(negedge clk);
    @(negedge clk);
    chequea("rst_ocupado", {31'h0, ocupado}, 32'h0);
    chequea("rst_listo", {31'h0, listo}, 32'h0);
    chequea("rst_cociente", cociente, 32'h0);
    chequea("rst_resto", resto, 32'h0);
    nreset = 1'b1;
    @(negedge clk);

    lanzar(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    espera("u100_7", occ);
    chequea("u100_7_ocupado", occ, 32'd33);
    @(negedge clk);

    lanzar(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    espera("s_m100_7", occ);
    @(negedge clk);

    lanzar(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2);
    espera("s_100_m7", occ);
    @(negedge clk);

    lanzar(32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    espera("u_div0", occ);
    chequea("u_div0_ocupado", occ, 32'd1);
    @(negedge clk);

    lanzar(32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    espera("s_div0", occ);
    @(negedge clk);

    lanzar(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
    espera("s_desborde", occ);
    chequea("s_desborde_ocupado", occ, 32'd1);
    @(negedge clk);

    lanzar(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
    espera("u_8000_ffff", occ);
    @(negedge clk);

    // Abort mid-operation: nothing pushed, so any listo would be flagged
    a = 32'd5000;
    b = 32'd3;
    con_signo = 1'b0;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (9) @(negedge clk);
    nreset = 1'b0;
    #1;
    chequea("abort_ocupado", {31'h0, ocupado}, 32'h0);
    chequea("abort_listo", {31'h0, listo}, 32'h0);
    chequea("abort_cociente", cociente, 32'h0);
    chequea("abort_resto", resto, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    listos = 0;
    repeat (40) @(negedge clk);
    chequea("abort_sin_listo", listos, 32'd0);

    lanzar(32'd15, 32'd10, 1'b0, 32'd1, 32'd5);
    espera("u15_10", occ);
    @(negedge clk);

    // inicio held high: second operation accepted on the edge ending the listo cycle
    a = 32'd1000;
    b = 32'd3;
    con_signo = 1'b0;
    inicio = 1'b1;
    t1 = ciclo + 1 + lat_esp(32'd1000, 32'd3, 1'b0);
    sb.push_back('{32'd333, 32'd1, t1});
    sb.push_back('{32'd15, 32'd2, t1 + 1 + lat_esp(32'd77, 32'd5, 1'b0)});
    @(negedge clk);
    a = 32'd77;
    b = 32'd5;
    espera("encadena_1", occ);
    @(negedge clk);
    inicio = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0000_0001;
    con_signo = 1'b1;
    espera("encadena_2", occ);
    @(negedge clk);
    @(negedge clk);

    chequea("sb_pendientes", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", total, fallos);
    $finish;
  end

endmodule
